// File: rtl/gpu_pkg.sv
// Shared types for the GPU instruction path: raster widths, decoder opcodes and the
// packed draw instruction that the buffer hands to the rasterizer.
package gpu_pkg;

  // Raster widths, matching the decoder's definitions (640x480, 8-bit colour).
  localparam int WIDTH_BITS   = 10;
  localparam int HEIGHT_BITS  = 9;
  localparam int CHANNEL_BITS = 8;

  localparam logic [3:0] OP_RESET     = 4'b0000;
  localparam logic [3:0] OP_SET_XY1   = 4'b0001;
  localparam logic [3:0] OP_SET_XY2   = 4'b0010;
  localparam logic [3:0] OP_SET_RAD   = 4'b0011;
  localparam logic [3:0] OP_DRAW_LINE = 4'b0100;
  localparam logic [3:0] OP_DRAW_RECT = 4'b0101;

  typedef struct packed {
    logic [3:0]              opcode;
    logic [WIDTH_BITS-1:0]   x1;
    logic [HEIGHT_BITS-1:0]  y1;
    logic [WIDTH_BITS-1:0]   x2;
    logic [HEIGHT_BITS-1:0]  y2;
    logic [WIDTH_BITS-1:0]   rad;
    logic [CHANNEL_BITS-1:0] r;
    logic [CHANNEL_BITS-1:0] g;
    logic [CHANNEL_BITS-1:0] b;
  } gpu_instr_t;

endpackage

// File: rtl/gpu_sync_fifo.sv
// Generic single-clock FIFO with registered occupancy; full/empty come from the count.
// Flush empties the queue without touching storage; a pop on a full FIFO frees room for a push.
module gpu_sync_fifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int PTR_BITS = $clog2(DEPTH)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                push_i,
  input  logic [WIDTH-1:0]    wdata_i,
  input  logic                pop_i,
  output logic [WIDTH-1:0]    rdata_o,
  output logic [PTR_BITS:0]   count_o,
  output logic                full_o,
  output logic                empty_o,
  output logic                push_ok_o
);

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [PTR_BITS-1:0] wr_ptr;
  logic [PTR_BITS-1:0] rd_ptr;
  logic [PTR_BITS:0]   count;
  logic                pop_ok;
  logic                push_ok;

  assign full_o    = (count == (PTR_BITS+1)'(DEPTH));
  assign empty_o   = (count == '0);
  assign pop_ok    = pop_i && !empty_o && !flush_i;
  assign push_ok   = push_i && !flush_i && (!full_o || pop_ok);
  assign push_ok_o = push_ok;
  assign count_o   = count;
  assign rdata_o   = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop_ok)      count <= count + 1'b1;
      else if (pop_ok && !push_ok) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok && !rst_i) mem[wr_ptr] <= wdata_i;
  end

endmodule

// File: rtl/gpu_instruction_buffer.sv
// Shadows decoder parameters and queues complete draw instructions for the rasterizer.
// Optional GPU_IBUF_DROP_CNT_EN adds a saturating dropped-push counter (drop_cnt_o).
import gpu_pkg::*;

module gpu_instruction_buffer #(
  parameter int DEPTH    = 8,
  parameter int PTR_BITS = $clog2(DEPTH)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    command_i,
  input  logic [3:0]              opcode_i,
  input  logic [WIDTH_BITS-1:0]   x1_i,
  input  logic [HEIGHT_BITS-1:0]  y1_i,
  input  logic [WIDTH_BITS-1:0]   x2_i,
  input  logic [HEIGHT_BITS-1:0]  y2_i,
  input  logic [WIDTH_BITS-1:0]   rad_i,
  input  logic [CHANNEL_BITS-1:0] r_i,
  input  logic [CHANNEL_BITS-1:0] g_i,
  input  logic [CHANNEL_BITS-1:0] b_i,
  input  logic                    write_enable_i,
  input  logic                    push_instruction_i,
  output gpu_instr_t              instr_o,
  output logic                    instr_valid_o,
  input  logic                    instr_ready_i,
  output logic                    full_o,
  output logic [PTR_BITS:0]       count_o,
  output logic                    overflow_o
`ifdef GPU_IBUF_DROP_CNT_EN
  ,
  output logic [7:0]              drop_cnt_o
`endif
);

  logic [WIDTH_BITS-1:0]   x1_q, x2_q, rad_q;
  logic [HEIGHT_BITS-1:0]  y1_q, y2_q;
  logic [CHANNEL_BITS-1:0] r_q, g_q, b_q;
  logic                    flush;
  logic                    push_req;
  logic                    push_ok;
  logic                    drop;
  logic                    empty;
  gpu_instr_t              entry;
  gpu_instr_t              head;

  assign flush    = command_i && (opcode_i == OP_RESET);
  assign push_req = push_instruction_i && !flush;
  assign drop     = push_req && !push_ok;

  // Coordinates come from the shadows as they stood before this edge; colour bypasses them.
  assign entry = '{opcode: opcode_i, x1: x1_q, y1: y1_q, x2: x2_q, y2: y2_q,
                   rad: rad_q, r: r_i, g: g_i, b: b_i};

  always_ff @(posedge clk_i) begin
    if (rst_i || flush) begin
      x1_q  <= '0;
      y1_q  <= '0;
      x2_q  <= '0;
      y2_q  <= '0;
      rad_q <= '0;
      r_q   <= '0;
      g_q   <= '0;
      b_q   <= '0;
    end else if (write_enable_i) begin
      case (opcode_i)
        OP_SET_XY1: begin
          x1_q <= x1_i;
          y1_q <= y1_i;
        end
        OP_SET_XY2: begin
          x2_q <= x2_i;
          y2_q <= y2_i;
        end
        OP_SET_RAD: rad_q <= rad_i;
        OP_DRAW_LINE, OP_DRAW_RECT: begin
          r_q <= r_i;
          g_q <= g_i;
          b_q <= b_i;
        end
        default: ;
      endcase
    end
  end

  // Overflow survives a soft flush; only a real reset clears it.
  always_ff @(posedge clk_i) begin
    if (rst_i)     overflow_o <= 1'b0;
    else if (drop) overflow_o <= 1'b1;
  end

`ifdef GPU_IBUF_DROP_CNT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i)                        drop_cnt_o <= '0;
    else if (drop && drop_cnt_o != 8'hFF) drop_cnt_o <= drop_cnt_o + 8'd1;
  end
`endif

  gpu_sync_fifo #(
    .WIDTH    ($bits(gpu_instr_t)),
    .DEPTH    (DEPTH),
    .PTR_BITS (PTR_BITS)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .flush_i   (flush),
    .push_i    (push_req),
    .wdata_i   (entry),
    .pop_i     (instr_ready_i),
    .rdata_o   (head),
    .count_o   (count_o),
    .full_o    (full_o),
    .empty_o   (empty),
    .push_ok_o (push_ok)
  );

  assign instr_valid_o = !empty;
  assign instr_o       = empty ? '0 : head;

endmodule

// File: tb/tb_gpu_instruction_buffer.sv
// Directed bench for gpu_instruction_buffer: vector table for the basic flow, then
// hand-written sequences for full/overflow, soft flush, mid-drain reset and drop counter.
import gpu_pkg::*;

module tb_gpu_instruction_buffer;

  logic                    clk_i = 1'b0;
  logic                    rst_i;
  logic                    command_i;
  logic [3:0]              opcode_i;
  logic [WIDTH_BITS-1:0]   x1_i, x2_i, rad_i;
  logic [HEIGHT_BITS-1:0]  y1_i, y2_i;
  logic [CHANNEL_BITS-1:0] r_i, g_i, b_i;
  logic                    write_enable_i;
  logic                    push_instruction_i;
  gpu_instr_t              instr_o;
  logic                    instr_valid_o;
  logic                    instr_ready_i;
  logic                    full_o;
  logic [3:0]              count_o;
  logic                    overflow_o;
`ifdef GPU_IBUF_DROP_CNT_EN
  logic [7:0]              drop_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  gpu_instruction_buffer #(.DEPTH(8)) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .command_i          (command_i),
    .opcode_i           (opcode_i),
    .x1_i               (x1_i),
    .y1_i               (y1_i),
    .x2_i               (x2_i),
    .y2_i               (y2_i),
    .rad_i              (rad_i),
    .r_i                (r_i),
    .g_i                (g_i),
    .b_i                (b_i),
    .write_enable_i     (write_enable_i),
    .push_instruction_i (push_instruction_i),
    .instr_o            (instr_o),
    .instr_valid_o      (instr_valid_o),
    .instr_ready_i      (instr_ready_i),
    .full_o             (full_o),
    .count_o            (count_o),
    .overflow_o         (overflow_o)
`ifdef GPU_IBUF_DROP_CNT_EN
    ,
    .drop_cnt_o         (drop_cnt_o)
`endif
  );

  typedef struct {
    logic                    we;
    logic                    push;
    logic                    ready;
    logic [3:0]              op;
    logic [WIDTH_BITS-1:0]   a;
    logic [HEIGHT_BITS-1:0]  b;
    logic [23:0]             rgb;
    logic                    exp_valid;
    logic [3:0]              exp_count;
    gpu_instr_t              exp_instr;
  } vec_t;

  vec_t vecs [12];

  function automatic gpu_instr_t mk(logic [3:0] op, int x1, int y1, int x2, int y2,
                                    int rad, logic [23:0] rgb);
    gpu_instr_t e;
    e = '{opcode: op, x1: WIDTH_BITS'(x1), y1: HEIGHT_BITS'(y1), x2: WIDTH_BITS'(x2),
          y2: HEIGHT_BITS'(y2), rad: WIDTH_BITS'(rad), r: rgb[23:16], g: rgb[15:8], b: rgb[7:0]};
    return e;
  endfunction

  function automatic vec_t mkv(logic we, logic push, logic ready, logic [3:0] op, int a, int b,
                               logic [23:0] rgb, logic ev, int ec, gpu_instr_t ei);
    vec_t v;
    v = '{we: we, push: push, ready: ready, op: op, a: WIDTH_BITS'(a), b: HEIGHT_BITS'(b),
          rgb: rgb, exp_valid: ev, exp_count: 4'(ec), exp_instr: ei};
    return v;
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    rst_i = 0; command_i = 0; opcode_i = 0; write_enable_i = 0; push_instruction_i = 0;
    instr_ready_i = 0; x1_i = 0; y1_i = 0; x2_i = 0; y2_i = 0; rad_i = 0;
    r_i = 0; g_i = 0; b_i = 0;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(logic [3:0] op, logic [23:0] rgb, logic ready);
    idle();
    opcode_i = op; push_instruction_i = 1; instr_ready_i = ready;
    {r_i, g_i, b_i} = rgb;
    step();
  endtask

  task automatic chk_reset_state(string tag);
    chk({tag, "_valid"}, instr_valid_o, 0);
    chk({tag, "_count"}, count_o, 0);
    chk({tag, "_full"},  full_o, 0);
    chk({tag, "_instr"}, instr_o, 0);
    chk({tag, "_ovf"},   overflow_o, 0);
  endtask

  initial begin
    vecs[0]  = mkv(1, 0, 0, OP_SET_XY1,   5,  7,  24'h0,      0, 0, '0);
    vecs[1]  = mkv(1, 0, 0, OP_SET_XY2,   20, 30, 24'h0,      0, 0, '0);
    vecs[2]  = mkv(0, 1, 0, OP_DRAW_LINE, 0,  0,  24'hFF0080, 1, 1, mk(4, 5, 7, 20, 30, 0, 24'hFF0080));
    vecs[3]  = mkv(0, 0, 1, OP_RESET,     0,  0,  24'h0,      0, 0, '0);
    vecs[4]  = mkv(1, 0, 0, OP_SET_RAD,   9,  0,  24'h0,      0, 0, '0);
    vecs[5]  = mkv(1, 0, 0, 4'b0110,      99, 99, 24'h0,      0, 0, '0);
    vecs[6]  = mkv(0, 1, 0, OP_DRAW_RECT, 0,  0,  24'h010203, 1, 1, mk(5, 5, 7, 20, 30, 9, 24'h010203));
    vecs[7]  = mkv(0, 1, 1, OP_DRAW_LINE, 0,  0,  24'h040506, 1, 1, mk(4, 5, 7, 20, 30, 9, 24'h040506));
    vecs[8]  = mkv(0, 0, 1, OP_RESET,     0,  0,  24'h0,      0, 0, '0);
    vecs[9]  = mkv(1, 1, 0, OP_SET_XY1,   40, 41, 24'h0A0B0C, 1, 1, mk(1, 5, 7, 20, 30, 9, 24'h0A0B0C));
    vecs[10] = mkv(0, 1, 1, OP_DRAW_LINE, 0,  0,  24'h000000, 1, 1, mk(4, 40, 41, 20, 30, 9, 24'h0));
    vecs[11] = mkv(0, 0, 1, OP_RESET,     0,  0,  24'h0,      0, 0, '0);

    idle();
    rst_i = 1;
    step();
    step();
    chk_reset_state("reset");
    idle();

    for (int i = 0; i < 12; i++) begin
      idle();
      write_enable_i = vecs[i].we;
      push_instruction_i = vecs[i].push;
      instr_ready_i = vecs[i].ready;
      opcode_i = vecs[i].op;
      x1_i = vecs[i].a; x2_i = vecs[i].a; rad_i = vecs[i].a;
      y1_i = vecs[i].b; y2_i = vecs[i].b;
      {r_i, g_i, b_i} = vecs[i].rgb;
      step();
      chk($sformatf("vec%0d_valid", i), instr_valid_o, vecs[i].exp_valid);
      chk($sformatf("vec%0d_count", i), count_o, vecs[i].exp_count);
      chk($sformatf("vec%0d_instr", i), instr_o, vecs[i].exp_instr);
      chk($sformatf("vec%0d_full", i), full_o, 0);
    end

    // Fill, full push+pop, overflow, ordered drain.
    idle(); rst_i = 1; step();
    for (int i = 0; i < 8; i++) push(OP_DRAW_RECT, 24'(i), 0);
    chk("fill_full", full_o, 1);
    chk("fill_count", count_o, 8);
    chk("fill_head", instr_o, mk(5, 0, 0, 0, 0, 0, 24'd0));
    push(OP_DRAW_RECT, 24'd8, 1);
    chk("pp_count", count_o, 8);
    chk("pp_ovf", overflow_o, 0);
    chk("pp_head", instr_o, mk(5, 0, 0, 0, 0, 0, 24'd1));
    push(OP_DRAW_RECT, 24'd9, 0);
    chk("drop_count", count_o, 8);
    chk("drop_ovf", overflow_o, 1);
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("drain_head%0d", i), instr_o, mk(5, 0, 0, 0, 0, 0, 24'(i)));
      idle(); instr_ready_i = 1; step();
    end
    chk("drained_valid", instr_valid_o, 0);
    chk("drained_full", full_o, 0);
    chk("drained_instr", instr_o, 0);

    // Soft flush keeps overflow, clears queue and shadows.
    idle(); write_enable_i = 1; opcode_i = OP_SET_XY1; x1_i = 3; y1_i = 4; step();
    idle(); write_enable_i = 1; opcode_i = OP_SET_RAD; rad_i = 11; step();
    for (int i = 0; i < 3; i++) push(OP_DRAW_LINE, 24'(i), 0);
    chk("preflush_count", count_o, 3);
    chk("preflush_head", instr_o, mk(4, 3, 4, 0, 0, 11, 24'd0));
    idle(); command_i = 1; opcode_i = OP_RESET; push_instruction_i = 1; instr_ready_i = 1; step();
    chk("flush_count", count_o, 0);
    chk("flush_valid", instr_valid_o, 0);
    chk("flush_ovf", overflow_o, 1);
    push(OP_DRAW_LINE, 24'h112233, 0);
    chk("postflush_instr", instr_o, mk(4, 0, 0, 0, 0, 0, 24'h112233));
    chk("postflush_count", count_o, 1);

    // Reset mid-drain.
    for (int i = 0; i < 4; i++) push(OP_DRAW_RECT, 24'(i), 0);
    chk("prerst_count", count_o, 5);
    idle(); instr_ready_i = 1; step();
    chk("middrain_count", count_o, 4);
    idle(); rst_i = 1; instr_ready_i = 1; step();
    chk_reset_state("midrst");
    push(OP_DRAW_RECT, 24'h445566, 0);
    chk("postrst_count", count_o, 1);
    chk("postrst_instr", instr_o, mk(5, 0, 0, 0, 0, 0, 24'h445566));
    chk("postrst_valid", instr_valid_o, 1);

`ifdef GPU_IBUF_DROP_CNT_EN
    idle(); rst_i = 1; step();
    chk("dropcnt_reset", drop_cnt_o, 0);
    for (int i = 0; i < 8; i++) push(OP_DRAW_RECT, 24'(i), 0);
    for (int i = 0; i < 3; i++) push(OP_DRAW_RECT, 24'h0, 0);
    chk("dropcnt_3", drop_cnt_o, 3);
    idle(); command_i = 1; opcode_i = OP_RESET; step();
    chk("dropcnt_flush", drop_cnt_o, 3);
    for (int i = 0; i < 8; i++) push(OP_DRAW_RECT, 24'(i), 0);
    for (int i = 0; i < 257; i++) push(OP_DRAW_RECT, 24'h0, 0);
    chk("dropcnt_sat", drop_cnt_o, 255);
    chk("dropcnt_count", count_o, 8);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
